// File: rtl/sqrt_sched_if.sv
// Requester, datapath and result signals of the psdsqrt scheduler.
// slave is the scheduler's view; master is the requester/datapath side.
interface sqrt_sched_if #(
  parameter int NBITSIN = 32,
  parameter int k       = 8
);
  localparam int XW = NBITSIN + k;
  localparam int RW = NBITSIN / 2;

  logic          req0;
  logic [XW-1:0] x0;
  logic          ack0;
  logic          req1;
  logic [XW-1:0] x1;
  logic          ack1;
  logic          dp_start;
  logic          dp_stop;
  logic [XW-1:0] dp_x;
  logic [RW-1:0] dp_sqrt;
  logic          busy;
  logic [RW-1:0] res;
  logic          res_id;
  logic          res_valid;

  modport slave (
    input  req0, x0, req1, x1, dp_sqrt,
    output ack0, ack1, dp_start, dp_stop, dp_x, busy, res, res_id, res_valid
  );

  modport master (
    output req0, x0, req1, x1, dp_sqrt,
    input  ack0, ack1, dp_start, dp_stop, dp_x, busy, res, res_id, res_valid
  );
endinterface

// File: rtl/sqrt_sched.sv
// Round-robin scheduler/sequencer for the shared psdsqrt datapath; CYCLES+3 edges grant-to-result.
// Optional abort input (START/RUN only) is built when SQRT_SCHED_ABORT_EN is defined.
module sqrt_sched #(
  parameter int NBITSIN = 32,
  parameter int k       = 8,
  parameter int CYCLES  = (NBITSIN + k) / 2
) (
  input  logic        clock,
  input  logic        reset,
`ifdef SQRT_SCHED_ABORT_EN
  input  logic        abort,
`endif
  sqrt_sched_if.slave bus
);
  localparam int XW = NBITSIN + k;
  localparam int RW = NBITSIN / 2;
  localparam int CW = $clog2(CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_RUN   = 3'd2,
    S_STOP  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ptr_q, ptr_d;
  logic          owner_q, owner_d;
  logic [XW-1:0] dp_x_q, dp_x_d;
  logic          ack0_q, ack0_d;
  logic          ack1_q, ack1_d;
  logic [RW-1:0] res_q, res_d;
  logic          res_id_q, res_id_d;
  logic          res_valid_q, res_valid_d;

  logic          any_req;
  logic          win1;
  logic          abort_hit;

  // ptr_q names the requester that wins a tie; a lone request always wins.
  always_comb begin
    any_req = bus.req0 | bus.req1;
    win1    = bus.req1 & (~bus.req0 | ptr_q);
  end

`ifdef SQRT_SCHED_ABORT_EN
  always_comb begin
    abort_hit = abort & ((state_q == S_START) | (state_q == S_RUN));
  end
`else
  always_comb begin
    abort_hit = 1'b0;
  end
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    dp_x_d      = dp_x_q;
    ack0_d      = 1'b0;
    ack1_d      = 1'b0;
    res_d       = res_q;
    res_id_d    = res_id_q;
    res_valid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          owner_d = win1;
          dp_x_d  = win1 ? bus.x1 : bus.x0;
          ack0_d  = ~win1;
          ack1_d  = win1;
          ptr_d   = ~win1;
          state_d = S_START;
        end
      end
      S_START: begin
        cnt_d   = CW'(CYCLES);
        state_d = S_RUN;
      end
      S_RUN: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        state_d = S_DONE;
      end
      S_DONE: begin
        // The datapath output register was loaded at the close of STOP.
        res_d       = bus.dp_sqrt;
        res_id_d    = owner_q;
        res_valid_d = 1'b1;
        state_d     = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (abort_hit) begin
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      ptr_q       <= 1'b0;
      owner_q     <= 1'b0;
      dp_x_q      <= '0;
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
      res_q       <= '0;
      res_id_q    <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      dp_x_q      <= dp_x_d;
      ack0_q      <= ack0_d;
      ack1_q      <= ack1_d;
      res_q       <= res_d;
      res_id_q    <= res_id_d;
      res_valid_q <= res_valid_d;
    end
  end

  assign bus.dp_start  = (state_q == S_START);
  assign bus.dp_stop   = (state_q == S_STOP);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.dp_x      = dp_x_q;
  assign bus.ack0      = ack0_q;
  assign bus.ack1      = ack1_q;
  assign bus.res       = res_q;
  assign bus.res_id    = res_id_q;
  assign bus.res_valid = res_valid_q;
endmodule

// File: tb/tb_sqrt_sched.sv
// Directed bench for sqrt_sched with a behavioural psdsqrt stand-in (integer sqrt loaded on dp_stop).
module tb_sqrt_sched;
  logic clock = 1'b0;
  logic reset = 1'b1;
`ifdef SQRT_SCHED_ABORT_EN
  logic abort = 1'b0;
`endif
  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  sqrt_sched_if #(.NBITSIN(32), .k(8)) bus();

  sqrt_sched #(.NBITSIN(32), .k(8)) dut (
    .clock (clock),
    .reset (reset),
`ifdef SQRT_SCHED_ABORT_EN
    .abort (abort),
`endif
    .bus   (bus)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [15:0] isqrt(input logic [39:0] v);
    longint r;
    r = 0;
    while ((r + 1) * (r + 1) <= longint'(v)) r++;
    return 16'(r);
  endfunction

  logic [15:0] dp_sqrt_r;
  assign bus.dp_sqrt = dp_sqrt_r;
  always @(posedge clock) begin
    if (reset) dp_sqrt_r <= '0;
    else if (bus.dp_stop) dp_sqrt_r <= isqrt(bus.dp_x);
  end

  int ack0_log[$], ack1_log[$], grant_log[$], start_log[$], stop_log[$];
  int rv_log[$], rv_res[$], rv_id[$];

  always @(negedge clock) begin
    if (bus.ack0) begin ack0_log.push_back(cyc); grant_log.push_back(0); end
    if (bus.ack1) begin ack1_log.push_back(cyc); grant_log.push_back(1); end
    if (bus.dp_start) start_log.push_back(cyc);
    if (bus.dp_stop) stop_log.push_back(cyc);
    if (bus.res_valid) begin
      rv_log.push_back(cyc);
      rv_res.push_back(int'(bus.res));
      rv_id.push_back(int'(bus.res_id));
    end
  end

  task automatic clear_logs();
    ack0_log.delete(); ack1_log.delete(); grant_log.delete();
    start_log.delete(); stop_log.delete();
    rv_log.delete(); rv_res.delete(); rv_id.delete();
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1; bus.req0 = 1'b0; bus.req1 = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  // Counts res_valid pulses seen from now; the expired budget is itself a failed comparison.
  task automatic wait_rv(input int n, input int budget, input string tag);
    int seen = 0;
    int i = 0;
    while (seen < n && i < budget) begin
      @(negedge clock);
      if (bus.res_valid) seen++;
      i++;
    end
    total++;
    if (seen < n) begin
      bad++;
      $display("FAIL %s timeout: res_valid pulses=%0d required=%0d", tag, seen, n);
    end
  endtask

  task automatic test_reset();
    @(negedge clock);
    reset = 1'b1; bus.req0 = 1'b1; bus.x0 = 40'd77;
    @(negedge clock);
    @(negedge clock);
    total++; if (bus.ack0 !== 1'b0) begin bad++; $display("FAIL reset_ack0 got=%b exp=0", bus.ack0); end
    total++; if (bus.ack1 !== 1'b0) begin bad++; $display("FAIL reset_ack1 got=%b exp=0", bus.ack1); end
    total++; if (bus.dp_start !== 1'b0 || bus.dp_stop !== 1'b0) begin bad++; $display("FAIL reset_dp got start=%b stop=%b exp=0,0", bus.dp_start, bus.dp_stop); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    total++; if (bus.res_valid !== 1'b0 || bus.res_id !== 1'b0) begin bad++; $display("FAIL reset_rv got rv=%b id=%b exp=0,0", bus.res_valid, bus.res_id); end
    total++; if (bus.res !== 16'd0 || bus.dp_x !== 40'd0) begin bad++; $display("FAIL reset_data got res=%0d dp_x=%0d exp=0,0", bus.res, bus.dp_x); end
    bus.req0 = 1'b0;
    reset = 1'b0;
  endtask

  task automatic test_single();
    int c;
    do_reset(); clear_logs();
    @(negedge clock);
    c = cyc; bus.req0 = 1'b1; bus.x0 = 40'd123456;
    @(negedge clock);
    total++; if (bus.ack0 !== 1'b1 || bus.dp_start !== 1'b1 || bus.busy !== 1'b1) begin
      bad++; $display("FAIL single_start got ack0=%b start=%b busy=%b exp=1,1,1", bus.ack0, bus.dp_start, bus.busy);
    end
    bus.req0 = 1'b0; bus.x0 = 40'd999;
    repeat (3) @(negedge clock);
    total++; if (bus.dp_x !== 40'd123456) begin bad++; $display("FAIL single_dp_x got=%0d exp=123456", bus.dp_x); end
    wait_rv(1, 40, "single");
    @(negedge clock);
    total++; if (bus.res !== 16'd351 || bus.res_valid !== 1'b0 || bus.busy !== 1'b0) begin
      bad++; $display("FAIL single_hold got res=%0d rv=%b busy=%b exp=351,0,0", bus.res, bus.res_valid, bus.busy);
    end
    total++; if (ack0_log.size() != 1 || ack1_log.size() != 0 || ack0_log[0] != c + 1) begin
      bad++; $display("FAIL single_ack got n0=%0d n1=%0d exp one ack0 at cycle %0d", ack0_log.size(), ack1_log.size(), c + 1);
    end
    total++; if (start_log.size() != 1 || start_log[0] != c + 1) begin
      bad++; $display("FAIL single_start_cyc got n=%0d exp one at %0d", start_log.size(), c + 1);
    end
    total++; if (stop_log.size() != 1 || stop_log[0] != c + 22) begin
      bad++; $display("FAIL single_stop_cyc got n=%0d first=%0d exp one at %0d", stop_log.size(), (stop_log.size() > 0) ? stop_log[0] : -1, c + 22);
    end
    total++; if (rv_log.size() != 1 || rv_log[0] != c + 24 || rv_res[0] != 351 || rv_id[0] != 0) begin
      bad++; $display("FAIL single_result got n=%0d cyc=%0d res=%0d id=%0d exp 1 at %0d res=351 id=0",
                      rv_log.size(), (rv_log.size() > 0) ? rv_log[0] : -1, (rv_res.size() > 0) ? rv_res[0] : -1,
                      (rv_id.size() > 0) ? rv_id[0] : -1, c + 24);
    end
  endtask

  task automatic test_simultaneous();
    int nrv = 0;
    do_reset(); clear_logs();
    @(negedge clock);
    bus.req0 = 1'b1; bus.x0 = 40'd109876;
    bus.req1 = 1'b1; bus.x1 = 40'd543210;
    for (int i = 0; i < 80 && nrv < 2; i++) begin
      @(negedge clock);
      if (bus.ack0) bus.req0 = 1'b0;
      if (bus.ack1) bus.req1 = 1'b0;
      if (bus.res_valid) nrv++;
    end
    @(negedge clock);
    total++; if (grant_log.size() != 2 || grant_log[0] != 0 || grant_log[1] != 1) begin
      bad++; $display("FAIL simul_order got n=%0d exp grants 0 then 1", grant_log.size());
    end
    total++; if (rv_res.size() != 2 || rv_res[0] != 331 || rv_id[0] != 0 || rv_res[1] != 737 || rv_id[1] != 1) begin
      bad++; $display("FAIL simul_results got n=%0d exp res 331/id0 then 737/id1", rv_res.size());
    end
    total++; if (rv_log.size() != 2 || rv_log[1] - rv_log[0] != 24) begin
      bad++; $display("FAIL simul_spacing got n=%0d gap=%0d exp 2 pulses gap 24", rv_log.size(), (rv_log.size() == 2) ? rv_log[1] - rv_log[0] : -1);
    end
  endtask

  task automatic test_fairness();
    int nrv = 0;
    int exp_g[4] = '{0, 1, 0, 1};
    do_reset(); clear_logs();
    @(negedge clock);
    bus.req0 = 1'b1; bus.x0 = 40'd12;
    bus.req1 = 1'b1; bus.x1 = 40'd13;
    for (int i = 0; i < 140 && nrv < 4; i++) begin
      @(negedge clock);
      if (bus.res_valid) nrv++;
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    @(negedge clock);
    total++; if (nrv != 4 || grant_log.size() != 4) begin
      bad++; $display("FAIL fair_count got results=%0d grants=%0d exp 4,4", nrv, grant_log.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        total++; if (grant_log[i] != exp_g[i] || rv_id[i] != exp_g[i] || rv_res[i] != 3) begin
          bad++; $display("FAIL fair_op%0d got grant=%0d id=%0d res=%0d exp %0d,%0d,3", i, grant_log[i], rv_id[i], rv_res[i], exp_g[i], exp_g[i]);
        end
      end
      total++; if (rv_log[3] - rv_log[0] != 72) begin
        bad++; $display("FAIL fair_rate got span=%0d exp 72", rv_log[3] - rv_log[0]);
      end
    end
  endtask

  task automatic test_ignore_busy();
    int nrv = 0;
    do_reset(); clear_logs();
    @(negedge clock);
    bus.req0 = 1'b1; bus.x0 = 40'd1057;
    @(negedge clock);
    bus.req0 = 1'b0;
    repeat (8) @(negedge clock);
    bus.req1 = 1'b1; bus.x1 = 40'd4291;
    @(negedge clock);
    total++; if (bus.dp_x !== 40'd1057 || bus.ack1 !== 1'b0) begin
      bad++; $display("FAIL busy_latch got dp_x=%0d ack1=%b exp 1057,0", bus.dp_x, bus.ack1);
    end
    for (int i = 0; i < 80 && nrv < 2; i++) begin
      @(negedge clock);
      if (bus.ack1) bus.req1 = 1'b0;
      if (bus.res_valid) nrv++;
    end
    @(negedge clock);
    total++; if (rv_res.size() != 2 || rv_res[0] != 32 || rv_id[0] != 0 || rv_res[1] != 65 || rv_id[1] != 1) begin
      bad++; $display("FAIL busy_results got n=%0d exp 32/id0 then 65/id1", rv_res.size());
    end
    total++; if (ack1_log.size() != 1 || rv_log.size() < 1 || ack1_log[0] != rv_log[0] + 1) begin
      bad++; $display("FAIL busy_grant got n=%0d exp one ack1 right after first res_valid", ack1_log.size());
    end
  endtask

  task automatic test_reset_mid_run();
    clear_logs();
    @(negedge clock);
    bus.req0 = 1'b1; bus.x0 = 40'd12;
    @(negedge clock);
    bus.req0 = 1'b0;
    repeat (10) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    total++; if (bus.busy !== 1'b0 || bus.res !== 16'd0 || bus.res_id !== 1'b0 || bus.dp_x !== 40'd0 || bus.dp_stop !== 1'b0) begin
      bad++; $display("FAIL midrst_outputs got busy=%b res=%0d id=%b dp_x=%0d stop=%b exp all 0",
                      bus.busy, bus.res, bus.res_id, bus.dp_x, bus.dp_stop);
    end
    reset = 1'b0;
    repeat (30) @(negedge clock);
    total++; if (stop_log.size() != 0 || rv_log.size() != 0) begin
      bad++; $display("FAIL midrst_abandon got stops=%0d results=%0d exp 0,0", stop_log.size(), rv_log.size());
    end
    @(negedge clock);
    bus.req0 = 1'b1; bus.x0 = 40'd12;
    @(negedge clock);
    bus.req0 = 1'b0;
    wait_rv(1, 40, "midrst_after");
    @(negedge clock);
    total++; if (bus.res !== 16'd3 || bus.res_id !== 1'b0) begin
      bad++; $display("FAIL midrst_after got res=%0d id=%b exp 3,0", bus.res, bus.res_id);
    end
  endtask

`ifdef SQRT_SCHED_ABORT_EN
  task automatic test_abort();
    do_reset(); clear_logs();
    @(negedge clock);
    bus.req0 = 1'b1; bus.x0 = 40'd1057;
    @(negedge clock);
    bus.req0 = 1'b0;
    repeat (5) @(negedge clock);
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b exp 0", bus.busy); end
    repeat (30) @(negedge clock);
    total++; if (stop_log.size() != 0 || rv_log.size() != 0) begin
      bad++; $display("FAIL abort_quiet got stops=%0d results=%0d exp 0,0", stop_log.size(), rv_log.size());
    end
    bus.req1 = 1'b1; bus.x1 = 40'd4291;
    @(negedge clock);
    bus.req1 = 1'b0;
    wait_rv(1, 40, "abort_after");
    @(negedge clock);
    total++; if (bus.res !== 16'd65 || bus.res_id !== 1'b1) begin
      bad++; $display("FAIL abort_after got res=%0d id=%b exp 65,1", bus.res, bus.res_id);
    end
  endtask
`endif

  initial begin
    bus.req0 = 1'b0; bus.x0 = '0;
    bus.req1 = 1'b0; bus.x1 = '0;
    test_reset();
    test_single();
    test_simultaneous();
    test_fairness();
    test_ignore_busy();
    test_reset_mid_run();
`ifdef SQRT_SCHED_ABORT_EN
    test_abort();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
endmodule
